mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter in front of a single memory port, one transaction in flight.
// Define ARB_RR_EN for round-robin conflict resolution; the default build gives LSU fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [3:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       grant_lsu;
    logic       handshake;
    logic       capture;

`ifdef ARB_RR_EN
    logic last_grant;

    // On a conflict the requester that did not win last time goes next.
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= OWN_IFU;
        end else if (handshake) begin
            last_grant <= lsu_req_ready ? OWN_LSU : OWN_IFU;
        end
    end
`else
    always_comb begin
        grant_lsu = lsu_req_valid;
    end
`endif

    // Readies are gated by rst so they drop immediately while reset is held.
    always_comb begin
        ifu_req_ready = rst && (state == ST_IDLE) && ifu_req_valid && !grant_lsu;
        lsu_req_ready = rst && (state == ST_IDLE) && grant_lsu;
        handshake     = ifu_req_ready || lsu_req_ready;
        capture       = ((state == ST_REQ) && mem_req_ready && mem_resp_valid) ||
                        ((state == ST_WAIT) && mem_resp_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            owner          <= OWN_IFU;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
        end else begin
            ifu_resp_valid <= capture && (owner == OWN_IFU);
            lsu_resp_valid <= capture && (owner == OWN_LSU);

            if (capture) begin
                if (owner == OWN_LSU) begin
                    lsu_rdata <= mem_rdata;
                end else begin
                    ifu_rdata <= mem_rdata;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        if (lsu_req_ready) begin
                            owner     <= OWN_LSU;
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wmask <= lsu_wmask;
                        end else begin
                            owner     <= OWN_IFU;
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= mem_resp_valid ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-timestamp transaction model checked every cycle,
// plus literal expectations for fetch, store, conflict, zero-latency and reset scenarios.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0000;
    endfunction

    // Memory responder: ready r_rdy cycles after a request appears, data r_rsp cycles after ready.
    int r_rdy = 0;
    int r_rsp = 0;
    initial begin
        logic [31:0] a;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        forever begin
            @(posedge clk); #1;
            if (rst && mem_req_valid) begin
                repeat (r_rdy) begin @(posedge clk); #1; end
                mem_req_ready = 1'b1;
                a = mem_addr;
                if (r_rsp == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = rd_of(a);
                end
                @(posedge clk); #1;
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b0;
                if (r_rsp > 0) begin
                    repeat (r_rsp - 1) begin @(posedge clk); #1; end
                    mem_resp_valid = 1'b1;
                    mem_rdata      = rd_of(a);
                    @(posedge clk); #1;
                    mem_resp_valid = 1'b0;
                end
            end
        end
    end

    // Transaction model: handshake, accept and response cycle stamps of the current transaction.
    int          m_hs, m_acc, m_rsp;
    logic        m_own, m_lg;
    logic [31:0] m_addr, m_wdata, m_ifu_rd, m_lsu_rd;
    logic        m_wen;
    logic [3:0]  m_wmask;

    task automatic model_reset();
        m_hs = -1; m_acc = -1; m_rsp = -1;
        m_own = 1'b0; m_lg = 1'b0;
        m_addr = '0; m_wdata = '0; m_wen = 1'b0; m_wmask = '0;
        m_ifu_rd = '0; m_lsu_rd = '0;
    endtask

    initial model_reset();
    always @(negedge rst) model_reset();

    always @(negedge clk) begin
        logic idle, pick_lsu, e_ifu_rdy, e_lsu_rdy, e_mreq, e_ifu_rv, e_lsu_rv;
        if (!rst) model_reset();
        idle      = (m_hs < 0) || (m_rsp >= 0 && cyc >= m_rsp + 2);
        pick_lsu  = lsu_req_valid && (!ifu_req_valid || (RR ? (m_lg == 1'b0) : 1'b1));
        e_ifu_rdy = rst && idle && ifu_req_valid && !pick_lsu;
        e_lsu_rdy = rst && idle && pick_lsu;
        e_mreq    = rst && m_hs >= 0 && m_acc < 0;
        e_ifu_rv  = rst && m_rsp >= 0 && cyc == m_rsp + 1 && !m_own;
        e_lsu_rv  = rst && m_rsp >= 0 && cyc == m_rsp + 1 && m_own;

        chk("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
        chk("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
        chk("mem_req_valid", mem_req_valid, e_mreq);
        chk("ifu_resp_valid", ifu_resp_valid, e_ifu_rv);
        chk("lsu_resp_valid", lsu_resp_valid, e_lsu_rv);
        chk("ifu_rdata", ifu_rdata, m_ifu_rd);
        chk("lsu_rdata", lsu_rdata, m_lsu_rd);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wen", mem_wen, m_wen);
        chk("mem_wmask", mem_wmask, m_wmask);
        if (!rst || m_wen) chk("mem_wdata", mem_wdata, m_wdata);

        if (rst) begin
            if (e_mreq && mem_req_ready) begin
                m_acc = cyc;
                if (mem_resp_valid) m_rsp = cyc;
            end else if (m_acc >= 0 && m_rsp < 0 && cyc > m_acc && mem_resp_valid) begin
                m_rsp = cyc;
            end
            if (m_rsp == cyc) begin
                if (m_own) m_lsu_rd = mem_rdata;
                else       m_ifu_rd = mem_rdata;
            end
            if (e_ifu_rdy || e_lsu_rdy) begin
                m_hs = cyc; m_acc = -1; m_rsp = -1;
                m_own = e_lsu_rdy; m_lg = e_lsu_rdy;
                m_addr  = e_lsu_rdy ? lsu_addr : ifu_addr;
                m_wen   = e_lsu_rdy ? lsu_wen : 1'b0;
                m_wdata = e_lsu_rdy ? lsu_wdata : 32'h0;
                m_wmask = e_lsu_rdy ? lsu_wmask : 4'h0;
            end
        end
    end

    // Wait for the negedge of cycle n (at least one negedge).
    task automatic at_cycle(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic wait_grant(input string nm, output int t, output logic to_lsu);
        t = -1;
        to_lsu = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                t = cyc;
                to_lsu = lsu_req_ready;
                break;
            end
        end
        if (t < 0) chk({nm, "_grant_timeout"}, 1, 0);
    endtask

    initial begin
        int   t, n;
        logic g;
        logic grants [2];

        rst = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        @(negedge clk);
        chk("reset_ifu_ready", ifu_req_ready, 0);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_ifu_rdata", ifu_rdata, 0);
        ifu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single IFU fetch: ready at T+1, data at T+3, response at T+4.
        r_rdy = 0; r_rsp = 2;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        wait_grant("fetch", t, g);
        chk("fetch_owner", g, 0);
        @(posedge clk); #1 ifu_req_valid = 1'b0;
        at_cycle(t + 3);
        chk("fetch_no_resp_T3", ifu_resp_valid, 0);
        at_cycle(t + 4);
        chk("fetch_resp_T4", ifu_resp_valid, 1);
        chk("fetch_rdata", ifu_rdata, 32'h0000_0413);
        chk("fetch_lsu_quiet", lsu_resp_valid, 0);
        at_cycle(t + 6);

        // Both requesters held valid across two grants.
        r_rdy = 0; r_rsp = 0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                grants[n] = lsu_req_ready;
                n++;
            end
        end
        chk("conflict_grant_count", n, 2);
        chk("conflict_first_lsu", grants[0], 1);
        chk("conflict_second", grants[1], RR ? 0 : 1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (6) @(posedge clk);

        // LSU half-word store with a slow memory keeps REQ for three cycles.
        r_rdy = 2; r_rsp = 1;
        #1;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        wait_grant("store", t, g);
        chk("store_owner", g, 1);
        @(posedge clk); #1 lsu_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            at_cycle(t + k);
            chk("store_req_valid", mem_req_valid, 1);
            chk("store_wen", mem_wen, 1);
            chk("store_wmask", mem_wmask, 4'b0011);
            chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("store_addr", mem_addr, 32'h8000_1000);
        end
        n = 0;
        for (int k = 4; k <= 10; k++) begin
            at_cycle(t + k);
            if (lsu_resp_valid) n++;
            if (k == 5) chk("store_resp_T5", lsu_resp_valid, 1);
        end
        chk("store_resp_pulses", n, 1);

        // Zero-latency memory: response at T+2, next accept at T+3.
        r_rdy = 0; r_rsp = 0;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        wait_grant("zero", t, g);
        @(posedge clk); #1 ifu_addr = 32'h8000_0104;
        at_cycle(t + 1);
        chk("zero_req_valid_T1", mem_req_valid, 1);
        at_cycle(t + 2);
        chk("zero_resp_T2", ifu_resp_valid, 1);
        chk("zero_rdata", ifu_rdata, rd_of(32'h8000_0100));
        chk("zero_no_ready_T2", ifu_req_ready, 0);
        at_cycle(t + 3);
        chk("zero_ready_T3", ifu_req_ready, 1);
        @(posedge clk); #1 ifu_req_valid = 1'b0;
        at_cycle(t + 8);

        // Reset asserted while waiting for data; the late response must be ignored.
        r_rdy = 0; r_rsp = 5;
        @(posedge clk); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        wait_grant("rstmid", t, g);
        @(posedge clk); #1 ifu_req_valid = 1'b0;
        at_cycle(t + 2);
        ifu_req_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rstmid_ifu_ready", ifu_req_ready, 0);
        chk("rstmid_mem_req_valid", mem_req_valid, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_ifu_rdata", ifu_rdata, 0);
        chk("rstmid_lsu_rdata", lsu_rdata, 0);
        chk("rstmid_mem_wmask", mem_wmask, 0);
        ifu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n = 0;
        for (int k = 4; k <= 12; k++) begin
            at_cycle(t + k);
            if (ifu_resp_valid || lsu_resp_valid) n++;
        end
        chk("rstmid_no_resp", n, 0);
        chk("rstmid_rdata_kept_zero", ifu_rdata, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
